// File: rtl/mem_bus_master_pkg.sv
// Shared types and constants for the RAM bus initiator and the RAM it talks to.
package mem_bus_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_WAIT,
    RD_CAP,
    RESP
  } state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Default geometry of the 16x8 RAM; the RAM instance uses the same values.
  localparam int MEM_ADDR_W = 4;
  localparam int MEM_DATA_W = 8;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_bus_master_tri_buf.sv
// Tri-state driver onto the shared RAM data bus; released to Z when en is low.
module mem_bus_master_tri_buf #(
  parameter int DATA_W = 8
) (
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  inout  wire  [DATA_W-1:0] bus
);

  assign bus = en ? d : {DATA_W{1'bz}};

endmodule

// File: rtl/mem_bus_master.sv
// Single-outstanding read/write initiator for a synchronous RAM with a shared
// tri-state data bus; sequences R_W/address and returns one response per request.
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int RD_WAIT = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_we,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] address,
  output logic              R_W,
  inout  wire  [DATA_W-1:0] Data_Bus
);

  state_t              state, state_next;
  logic [ADDR_W-1:0]   address_next;
  logic                rw_next;
  logic [DATA_W-1:0]   wdata_q, wdata_next;
  logic                resp_we_next;
  logic [DATA_W-1:0]   resp_rdata_next;
  logic [WAIT_W-1:0]   wait_cnt, wait_next;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      address    <= '0;
      R_W        <= RW_READ;
      wdata_q    <= '0;
      resp_we    <= 1'b0;
      resp_rdata <= '0;
      wait_cnt   <= '0;
    end else begin
      state      <= state_next;
      address    <= address_next;
      R_W        <= rw_next;
      wdata_q    <= wdata_next;
      resp_we    <= resp_we_next;
      resp_rdata <= resp_rdata_next;
      wait_cnt   <= wait_next;
    end
  end

  always_comb begin
    state_next      = state;
    address_next    = address;
    rw_next         = R_W;
    wdata_next      = wdata_q;
    resp_we_next    = resp_we;
    resp_rdata_next = resp_rdata;
    wait_next       = wait_cnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          address_next = req_addr;
          wdata_next   = req_wdata;
          resp_we_next = req_we;
          if (req_we) begin
            rw_next    = RW_WRITE;
            state_next = WR;
          end else begin
            rw_next    = RW_READ;
            state_next = RD_ADDR;
          end
        end
      end
      WR: begin
        // The RAM stores on this closing edge; turn the bus around on the same edge.
        rw_next         = RW_READ;
        resp_rdata_next = '0;
        state_next      = RESP;
      end
      RD_ADDR: begin
        if (RD_WAIT == 0) begin
          state_next = RD_CAP;
        end else begin
          wait_next  = WAIT_W'(RD_WAIT);
          state_next = mem_bus_master_pkg::RD_WAIT;
        end
      end
      mem_bus_master_pkg::RD_WAIT: begin
        wait_next = wait_cnt - 1'b1;
        if (wait_cnt == WAIT_W'(1)) state_next = RD_CAP;
      end
      RD_CAP: begin
        resp_rdata_next = Data_Bus;
        state_next      = RESP;
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  // Drive enable is derived from the registered R_W, so ownership flips on one edge.
  mem_bus_master_tri_buf #(.DATA_W(DATA_W)) u_tri_buf (
    .en  (R_W == RW_WRITE),
    .d   (wdata_q),
    .bus (Data_Bus)
  );

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench: two initiators (RD_WAIT=0 and RD_WAIT=3), each with a behavioural 16x8 RAM.
module tb_mem_bus_master;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_we;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       resp_ready;
  int         sel;

  logic       req_valid0, req_ready0, resp_valid0, resp_we0, busy0, rw0;
  logic [7:0] resp_rdata0;
  logic [3:0] address0;
  wire  [7:0] bus0;
  logic       req_valid3, req_ready3, resp_valid3, resp_we3, busy3, rw3;
  logic [7:0] resp_rdata3;
  logic [3:0] address3;
  wire  [7:0] bus3;

  logic [7:0] mem0 [16];
  logic [7:0] mem3 [16];
  logic [7:0] ram_rd0, ram_rd3;
  int         wr_cnt0 = 0;
  int         wr_cnt3 = 0;

  int checks = 0;
  int errors = 0;

  assign req_valid0 = req_valid && (sel == 0);
  assign req_valid3 = req_valid && (sel == 3);

  mem_bus_master #(.ADDR_W(4), .DATA_W(8), .RD_WAIT(0)) dut0 (
    .CLK(clk), .RST_N(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid0), .resp_ready(resp_ready), .resp_we(resp_we0),
    .resp_rdata(resp_rdata0), .busy(busy0), .address(address0), .R_W(rw0),
    .Data_Bus(bus0)
  );

  mem_bus_master #(.ADDR_W(4), .DATA_W(8), .RD_WAIT(3)) dut3 (
    .CLK(clk), .RST_N(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid3), .resp_ready(resp_ready), .resp_we(resp_we3),
    .resp_rdata(resp_rdata3), .busy(busy3), .address(address3), .R_W(rw3),
    .Data_Bus(bus3)
  );

  // Synchronous RAMs: write when R_W=0, otherwise latch the addressed word and drive it.
  always @(posedge clk) begin
    if (!rw0) begin
      mem0[address0] <= bus0;
      wr_cnt0 <= wr_cnt0 + 1;
    end else begin
      ram_rd0 <= mem0[address0];
    end
    if (!rw3) begin
      mem3[address3] <= bus3;
      wr_cnt3 <= wr_cnt3 + 1;
    end else begin
      ram_rd3 <= mem3[address3];
    end
  end
  assign bus0 = rw0 ? ram_rd0 : 8'hzz;
  assign bus3 = rw3 ? ram_rd3 : 8'hzz;

  // Views of whichever initiator is currently selected.
  logic       c_req_ready, c_resp_valid, c_resp_we, c_busy, c_rw;
  logic [7:0] c_rdata, c_bus;
  logic [3:0] c_addr;
  int         c_wr_cnt;
  always_comb begin
    c_req_ready  = (sel == 3) ? req_ready3  : req_ready0;
    c_resp_valid = (sel == 3) ? resp_valid3 : resp_valid0;
    c_resp_we    = (sel == 3) ? resp_we3    : resp_we0;
    c_busy       = (sel == 3) ? busy3       : busy0;
    c_rw         = (sel == 3) ? rw3         : rw0;
    c_rdata      = (sel == 3) ? resp_rdata3 : resp_rdata0;
    c_bus        = (sel == 3) ? bus3        : bus0;
    c_addr       = (sel == 3) ? address3    : address0;
    c_wr_cnt     = (sel == 3) ? wr_cnt3     : wr_cnt0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full transaction on the selected initiator, with optional response backpressure.
  task automatic xact(input logic we, input logic [3:0] addr, input logic [7:0] wd,
                      input int hold, input int exp_lat, input logic [7:0] exp_rd);
    int lat;
    int w0;
    @(negedge clk);
    check("req_ready_idle", 32'(c_req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    w0 = c_wr_cnt;
    check("address", 32'(c_addr), 32'(addr));
    check("busy", 32'(c_busy), 32'd1);
    if (we) begin
      check("wr_rw", 32'(c_rw), 32'd0);
      check("wr_bus", 32'(c_bus), 32'(wd));
    end else begin
      check("rd_rw", 32'(c_rw), 32'd1);
    end
    lat = 0;
    while (!c_resp_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_we", 32'(c_resp_we), 32'(we));
    check("resp_rdata", 32'(c_rdata), we ? 32'd0 : 32'(exp_rd));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", 32'(c_resp_valid), 32'd1);
      check("hold_rdata", 32'(c_rdata), we ? 32'd0 : 32'(exp_rd));
      check("hold_ready", 32'(c_req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_done", 32'(c_resp_valid), 32'd0);
    check("ready_again", 32'(c_req_ready), 32'd1);
    check("rw_low_cycles", 32'(c_wr_cnt - w0), we ? 32'd1 : 32'd0);
    $display("xact dut=%0d we=%0d addr=%0h wdata=%0h rdata=%0h lat=%0d hold=%0d",
             sel, we, addr, wd, c_rdata, lat, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0; sel = 0;
    #23 rst_n = 1'b1;

    @(negedge clk);
    check("rst_req_ready", 32'(req_ready0), 32'd1);
    check("rst_resp_valid", 32'(resp_valid0), 32'd0);
    check("rst_resp_we", 32'(resp_we0), 32'd0);
    check("rst_resp_rdata", 32'(resp_rdata0), 32'd0);
    check("rst_rw", 32'(rw0), 32'd1);
    check("rst_address", 32'(address0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);

    // Write then read back
    xact(1'b1, 4'h3, 8'hA5, 0, 1, 8'h00);
    xact(1'b0, 4'h3, 8'h00, 0, 2, 8'hA5);

    // Backpressure on a read
    xact(1'b1, 4'hF, 8'h3C, 0, 1, 8'h00);
    xact(1'b0, 4'hF, 8'h00, 5, 2, 8'h3C);

    // Bus turnaround, alternating
    xact(1'b1, 4'h0, 8'h11, 0, 1, 8'h00);
    xact(1'b0, 4'h0, 8'h00, 0, 2, 8'h11);
    xact(1'b1, 4'h0, 8'h11, 0, 1, 8'h00);
    xact(1'b0, 4'h0, 8'h00, 0, 2, 8'h11);

    // Slow-memory build
    sel = 3;
    xact(1'b1, 4'h7, 8'h5E, 0, 1, 8'h00);
    xact(1'b0, 4'h7, 8'h00, 0, 5, 8'h5E);
    xact(1'b0, 4'h7, 8'h00, 2, 5, 8'h5E);
    sel = 0;

    // Reset in the middle of a write
    xact(1'b1, 4'h2, 8'h00, 0, 1, 8'h00);
    wc = wr_cnt0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 4'h2; req_wdata = 8'hFF;
    @(posedge clk);
    #2;
    check("midwr_rw_before", 32'(rw0), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midwr_rst_rw", 32'(rw0), 32'd1);
    check("midwr_rst_bus", 32'(bus0), 32'(ram_rd0));
    check("midwr_rst_busy", 32'(busy0), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midwr_no_write", 32'(wr_cnt0 - wc), 32'd0);
    check("midwr_resp_valid", 32'(resp_valid0), 32'd0);
    check("midwr_req_ready", 32'(req_ready0), 32'd1);
    xact(1'b0, 4'h2, 8'h00, 0, 2, 8'h00);

    // Address sweep
    wc = wr_cnt0;
    for (int i = 0; i < 16; i++) xact(1'b1, 4'(i), 8'(i) ^ 8'h5A, 0, 1, 8'h00);
    check("sweep_writes", 32'(wr_cnt0 - wc), 32'd16);
    for (int i = 0; i < 16; i++) xact(1'b0, 4'(i), 8'h00, 0, 2, 8'(i) ^ 8'h5A);
    check("sweep_no_extra", 32'(wr_cnt0 - wc), 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- CPU-side initiator for the 16x8 synchronous RAM port (address, R_W, shared tri-state Data_Bus).
- Accepts one read/write request at a time on a valid/ready interface and sequences the RAM bus with correct turnaround.
- Captures read data from the shared bus and returns a single response per request.
- Sits between the Mano control unit / AR-DR register path and the RAM.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, data bus width.
- RD_WAIT, 0, extra idle cycles between read address phase and capture (0..15), for slower memory models.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  target word.
- req_wdata  input  DATA_W  write data.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer takes response.
- resp_we  output  1  echoes req_we of the completed request.
- resp_rdata  output  DATA_W  read data; 0 for writes.
- busy  output  1  high in any state except IDLE.
- address  output  ADDR_W  to RAM.
- R_W  output  1  to RAM; 1 = read, 0 = write.
- Data_Bus  inout  DATA_W  shared RAM data bus.

Behaviour:
- Reset (RST_N low, async):
  - state=IDLE; address=0; R_W=1; bus driver off (Data_Bus released to Z by this block).
  - req_ready=1 once released; resp_valid=0; resp_we=0; resp_rdata=0; wait counter=0.
- Bus ownership:
  - Block drives Data_Bus only while R_W=0; otherwise high-Z.
  - R_W, address and the drive-enable are registered and change on the same edge. This gives no overlap with the RAM's read driver, which is gated by R_W.
- States: IDLE, WR, RD_ADDR, RD_WAIT, RD_CAP, RESP.
- IDLE: req_ready=1. Accept on req_valid&&req_ready at edge E0.
  - Latch req_addr to address, req_wdata to an internal register, req_we to resp_we.
  - Write: go to WR with R_W=0. Read: go to RD_ADDR with R_W=1.
- WR (cycle E0..E1): Data_Bus=wdata. The RAM stores at E1. At E1: R_W<=1, drive off, resp_rdata<=0, go to RESP.
- RD_ADDR (E0..E1): the RAM latches the word at E1.
  - If RD_WAIT=0, go to RD_CAP. Otherwise load counter=RD_WAIT and go to RD_WAIT.
- RD_WAIT: decrement each cycle; at count 1, go to RD_CAP.
- RD_CAP: at the closing edge, resp_rdata<=Data_Bus and go to RESP.
- Read latency: resp_valid rises 2+RD_WAIT edges after accept. Write latency: 1 edge.
- RESP: resp_valid=1. resp_we/resp_rdata stay stable while resp_valid&&!resp_ready.
  - On resp_ready, resp_valid<=0 and go to IDLE.
  - A new request can be accepted the following cycle (no back-to-back accept in RESP).
- address holds its last value outside transactions; R_W stays 1. The RAM read re-latching in these cycles is harmless.
- req_* are ignored outside IDLE; upstream must hold them until req_ready.
- Reset asserted mid-WR before E1: R_W returns to 1 immediately and no write occurs. Reset mid-read: the response is discarded.
- X/Z on Data_Bus in RD_CAP is captured as-is; the bench flags it.

Decomposition:
- Shared package holds:
  - state enum: IDLE, WR, RD_ADDR, RD_WAIT, RD_CAP, RESP.
  - constants: RW_READ=1, RW_WRITE=0.
  - default widths ADDR_W/DATA_W, shared with the RAM instance.
- Optional sub-module tri_buf: DATA_W-bit tri-state driver (en, d, bus). Everything else stays flat.

Test Plan:
- Write then read: write addr 4'h3 data 8'hA5, then read 4'h3. Expect:
  - R_W=0 for exactly one cycle with Data_Bus=A5.
  - read resp_rdata=8'hA5, resp_we=0, valid 2 edges after accept.
- Backpressure: hold resp_ready=0 for 5 cycles after a read of 4'hF preloaded 8'h3C. Expect:
  - resp_valid and resp_rdata=8'h3C stable throughout.
  - req_ready=0 throughout; one response only.
- Bus turnaround: alternate write 4'h0<=8'h11 and read 4'h0. Expect no cycle where both the block and the RAM drive Data_Bus (no X on bus), and read 8'h11.
- RD_WAIT=3 build: read 4'h7 (preloaded 8'h5E). Expect resp_valid 5 edges after accept, data 8'h5E.
- Reset mid-write: assert RST_N low during WR for addr 4'h2 (old 8'h00, new 8'hFF). Expect:
  - R_W=1 and bus Z immediately.
  - subsequent read of 4'h2 returns 8'h00.
  - resp_valid=0, req_ready=1 after release.
- Address sweep: write i^8'h5A to all 16 addresses, read them back. Expect all match and address wraps 4'hF->4'h0 with no spurious writes.
